sim_ctrl: RTL and testbench
===========================

Name: sim_ctrl

Overview:
- Memory-mapped simulation-control peripheral on the CPU data bus. It is the inside end of the pass/fail/halt reporting path.
- Software writes a result code and console bytes to it. The block classifies the result, drains the console, then asserts halt.
- It also runs a free cycle counter and a watchdog, so a hung program still terminates with a defined status.

Parameters:
- TIMEOUT, 10000, watchdog limit in cycles counted from reset release.
- DRAIN_CYCLES, 2, minimum cycles spent in DRAIN before halt asserts.
- FIFO_DEPTH, 8, console FIFO entries; must be a power of 2.
- PASS_CODE, 32'h55, result value classified as pass.
- FAIL_CODE, 32'haa, result value classified as fail.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- we  in  1  bus write strobe, one write per cycle.
- addr  in  2  word offset: 0 RESULT, 1 CONSOLE, 2 CYCLE, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- halt  out  1  program finished; held until reset.
- status  out  3  0 RUN, 1 PASS, 2 FAIL, 3 ERROR, 4 TIMEOUT.
- console_valid  out  1  console byte available.
- console_data  out  8  console byte, FIFO head.
- console_ready  in  1  consumer accepts the byte when valid and ready are both high on a rising edge.
- overflow  out  1  sticky: a console byte was dropped.

Behaviour:
- Reset (async assert, sync release): state RUN, halt=0, status=0, cycle=0, FIFO empty, console_valid=0, overflow=0.
- FSM RUN:
  - RUN→DRAIN on a RESULT write (we & addr==0). status is latched the same edge: wdata==PASS_CODE→1, FAIL_CODE→2, otherwise→3.
  - RUN→DRAIN with status=4 when cycle==TIMEOUT-1 at the edge and there is no RESULT write.
  - If a RESULT write and the timeout coincide, the write wins.
- FSM DRAIN:
  - A drain counter starts at 0 on entry and increments each cycle, saturating.
  - DRAIN→HALTED when drain counter ≥ DRAIN_CYCLES-1 and the FIFO is empty, with no push or pop pending that cycle.
  - Further RESULT writes are ignored; status never changes after leaving RUN.
- FSM HALTED:
  - halt=1 registered. Terminal until rst.
  - All writes are ignored.
- Cycle counter: 32-bit, +1 per cycle in RUN and DRAIN, frozen in HALTED, wraps at 2^32.
  - The watchdog compares the full counter, so it never wraps before TIMEOUT.
- Console FIFO:
  - CONSOLE write pushes wdata[7:0] in RUN and DRAIN.
  - Push while full drops the byte and sets overflow; overflow clears only on rst.
  - Simultaneous push and pop while full: the pop frees a slot, so the push is accepted with no overflow.
  - Simultaneous push and pop while empty: the byte is stored and console_valid rises the next cycle. There is no bypass.
  - console_data is stable while console_valid=1 and console_ready=0.
  - Bytes are delivered in order. Pointers wrap modulo FIFO_DEPTH with an extra bit for full/empty.
- Reads (combinational):
  - addr 0 returns the latched result word, 0 before any write.
  - addr 1 returns {23'b0, overflow, count-free bits zero, FIFO occupancy in [4:0]}.
  - addr 2 returns cycle.
  - addr 3 returns {28'b0, halt, status}.
- Reset mid-DRAIN or in HALTED returns to the reset state; FIFO contents are lost.

Test Plan:
- Pass path: RESULT write 32'h55 at cycle 20, console_ready=1 → status=1 one edge later; halt=1 at cycle 22 (DRAIN_CYCLES=2); CYCLE read frozen at 22.
- Fail/error classification: writes 32'haa, 32'h0, 32'h56 in separate runs → status 2, 3, 3; a second RESULT write of 32'h55 in DRAIN leaves status unchanged.
- Console drain gating: push "OK\n" (3 bytes) with console_ready=0, then write RESULT 32'h55 → halt stays 0. Raise console_ready → bytes 4F, 4B, 0A delivered in order; halt asserts after the last pop.
- Overflow: 9 pushes with ready=0 and depth 8 → occupancy 8, overflow=1, 9th byte absent. Push and pop in the same cycle while full → no new overflow event, occupancy stays 8.
- Watchdog: no RESULT write, TIMEOUT=100 → status=4 at edge 100; halt at edge 101 with FIFO empty. RESULT write on the timeout edge → status=1 instead.
- Async reset: assert rst mid-DRAIN with 3 queued bytes → all outputs return to reset values immediately, without a clock edge; normal pass path works after release.

Source files
------------

// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation-control peripheral on the CPU data bus.
// Classifies the result code, drains console bytes, then holds halt.
module sim_ctrl #(
    parameter int          TIMEOUT      = 10000,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] PASS_CODE    = 32'h55,
    parameter logic [31:0] FAIL_CODE    = 32'haa
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        halt,
    output logic [2:0]  status,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // The entry edge counts as the first cycle spent draining.
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_ERROR   = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_cycle;
    logic [31:0] r_result;
    logic [2:0]  r_status;
    logic        r_halt;
    logic        r_overflow;
    logic [15:0] r_drain_cnt;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic        w_active;
    logic        w_res_wr;
    logic        w_con_wr;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_timeout;
    logic [15:0] w_drain_inc;
    logic        w_drain_ok;
    logic [2:0]  w_class;
    logic [4:0]  w_occ;

    assign w_active    = (r_state != S_HALTED);
    assign w_res_wr    = we && (addr == 2'd0);
    assign w_con_wr    = we && (addr == 2'd1) && w_active;
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop       = !w_empty && console_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_push      = w_con_wr && (!w_full || w_pop);
    assign w_drop      = w_con_wr && w_full && !w_pop;
    assign w_timeout   = (r_cycle == 32'(TIMEOUT - 1));
    assign w_drain_inc = (r_drain_cnt == '1) ? r_drain_cnt : r_drain_cnt + 16'd1;
    assign w_drain_ok  = ({16'b0, w_drain_inc} >= 32'(DRAIN_LAST));
    assign w_occ       = 5'(w_count);

    // Classify the written result word.
    always_comb begin
        w_class = ST_ERROR;
        if (wdata == PASS_CODE) begin
            w_class = ST_PASS;
        end else if (wdata == FAIL_CODE) begin
            w_class = ST_FAIL;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a result write beats a coincident timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_res_wr || w_timeout) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_ok && w_empty && !w_con_wr && !w_pop) begin
                    w_next = S_HALTED;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_RUN;
        endcase
    end

    // Latch status and result word only while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= ST_RUN;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            if (w_res_wr) begin
                r_status <= w_class;
                r_result <= wdata;
            end else if (w_timeout) begin
                r_status <= ST_TIMEOUT;
            end
        end
    end

    // Registered halt, raised on entry to HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= (w_next == S_HALTED);
        end
    end

    // Free-running cycle counter, frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (w_active) begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Saturating count of cycles spent in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= w_drain_inc;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Console storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wdata[7:0];
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0: rdata = r_result;
            2'd1: rdata = {23'b0, r_overflow, 3'b0, w_occ};
            2'd2: rdata = r_cycle;
            2'd3: rdata = {28'b0, r_halt, r_status};
            default: rdata = '0;
        endcase
    end

    assign halt          = r_halt;
    assign status        = r_status;
    assign overflow      = r_overflow;
    assign console_valid = !w_empty;
    assign console_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: directed self-checking bench for sim_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic        console_ready = 1'b0;
    logic [31:0] rdata;
    logic        halt;
    logic [2:0]  status;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        overflow;

    int n_run  = 0;
    int n_fail = 0;

    sim_ctrl #(
        .TIMEOUT      (100),
        .DRAIN_CYCLES (2),
        .FIFO_DEPTH   (8),
        .PASS_CODE    (32'h55),
        .FAIL_CODE    (32'haa)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .halt          (halt),
        .status        (status),
        .console_valid (console_valid),
        .console_data  (console_data),
        .console_ready (console_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_reset();
        we            = 1'b0;
        console_ready = 1'b0;
        rst           = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    logic [31:0] d;
    logic [31:0] codes [3];
    logic [31:0] cls   [3];
    logic [7:0]  ok_b  [3];
    logic [7:0]  ov_b  [8];

    initial begin
        codes = '{32'haa, 32'h0, 32'h56};
        cls   = '{32'd2, 32'd3, 32'd3};
        ok_b  = '{8'h4f, 8'h4b, 8'h0a};
        ov_b  = '{8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'haa};

        // Reset state
        step(1);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_valid", 32'(console_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rd(2'd2, d); chk("rst_cycle", d, 32'd0);
        rd(2'd0, d); chk("rst_result", d, 32'd0);
        rd(2'd1, d); chk("rst_console", d, 32'd0);
        step(1);
        rst = 1'b0;

        // Pass path
        do_reset();
        console_ready = 1'b1;
        step(20);
        rd(2'd2, d); chk("pass_cyc20", d, 32'd20);
        wr(2'd0, 32'h55);
        chk("pass_status", 32'(status), 32'd1);
        chk("pass_nohalt", 32'(halt), 32'd0);
        step(1);
        chk("pass_halt", 32'(halt), 32'd1);
        rd(2'd2, d); chk("pass_cyc22", d, 32'd22);
        step(3);
        rd(2'd2, d); chk("pass_frozen", d, 32'd22);
        rd(2'd0, d); chk("pass_result", d, 32'h55);
        rd(2'd3, d); chk("pass_statreg", d, 32'h9);
        wr(2'd1, 32'h41);
        rd(2'd1, d); chk("halted_nopush", d, 32'd0);

        // Fail / error classification, late RESULT ignored
        for (int i = 0; i < 3; i++) begin
            do_reset();
            step(2);
            wr(2'd0, codes[i]);
            chk($sformatf("class%0d", i), 32'(status), cls[i]);
            wr(2'd0, 32'h55);
            chk($sformatf("class%0d_keep", i), 32'(status), cls[i]);
            rd(2'd0, d);
            chk($sformatf("class%0d_word", i), d, codes[i]);
            chk($sformatf("class%0d_halt", i), 32'(halt), 32'd1);
        end

        // Console drain gating
        do_reset();
        wr(2'd1, 32'h4f);
        wr(2'd1, 32'h4b);
        wr(2'd1, 32'h0a);
        rd(2'd1, d); chk("con_occ3", d, 32'd3);
        wr(2'd0, 32'h55);
        chk("con_status", 32'(status), 32'd1);
        step(5);
        chk("con_gated", 32'(halt), 32'd0);
        chk("con_stable", 32'(console_data), 32'h4f);
        console_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("con_valid%0d", i), 32'(console_valid), 32'd1);
            chk($sformatf("con_byte%0d", i), 32'(console_data), 32'(ok_b[i]));
            step(1);
        end
        chk("con_empty", 32'(console_valid), 32'd0);
        chk("con_lastpop", 32'(halt), 32'd0);
        step(1);
        chk("con_halt", 32'(halt), 32'd1);

        // Overflow and push+pop while full
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            wr(2'd1, 32'(i));
        end
        rd(2'd1, d); chk("ovf_full", d, 32'h008);
        console_ready = 1'b1;
        wr(2'd1, 32'haa);
        console_ready = 1'b0;
        rd(2'd1, d); chk("ovf_pushpop", d, 32'h008);
        chk("ovf_head", 32'(console_data), 32'h02);
        wr(2'd1, 32'hbb);
        rd(2'd1, d); chk("ovf_drop", d, 32'h108);
        chk("ovf_flag", 32'(overflow), 32'd1);
        console_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_byte%0d", i), 32'(console_data), 32'(ov_b[i]));
            step(1);
        end
        chk("ovf_empty", 32'(console_valid), 32'd0);

        // Watchdog
        do_reset();
        step(99);
        chk("wd_run", 32'(status), 32'd0);
        step(1);
        chk("wd_status", 32'(status), 32'd4);
        chk("wd_nohalt", 32'(halt), 32'd0);
        rd(2'd2, d); chk("wd_cyc100", d, 32'd100);
        step(1);
        chk("wd_halt", 32'(halt), 32'd1);
        rd(2'd2, d); chk("wd_cyc101", d, 32'd101);
        rd(2'd3, d); chk("wd_statreg", d, 32'hc);

        // RESULT write on the timeout edge wins
        do_reset();
        step(99);
        wr(2'd0, 32'h55);
        chk("race_status", 32'(status), 32'd1);

        // Asynchronous reset mid-DRAIN
        do_reset();
        wr(2'd1, 32'h31);
        wr(2'd1, 32'h32);
        wr(2'd1, 32'h33);
        wr(2'd0, 32'h55);
        chk("ar_pre_valid", 32'(console_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_halt", 32'(halt), 32'd0);
        chk("ar_status", 32'(status), 32'd0);
        chk("ar_valid", 32'(console_valid), 32'd0);
        chk("ar_ovf", 32'(overflow), 32'd0);
        rd(2'd1, d); chk("ar_occ", d, 32'd0);
        step(2);
        rst = 1'b0;
        rd(2'd2, d); chk("ar_cyc0", d, 32'd0);
        step(3);
        wr(2'd0, 32'h55);
        chk("ar_pass", 32'(status), 32'd1);
        step(1);
        chk("ar_halt2", 32'(halt), 32'd1);
        rd(2'd2, d); chk("ar_cyc5", d, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
